// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for a 5-stage core.
// Operand forwarding, load-use stalls, redirect flushes, data-memory wait
// stalls and an orderly halt drain.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*/ex_*/mem_*/wb_*       register ids and control bits of each stage
//   id_halt, wb_halt           halt in ID / halt retiring in WB
//   *_write                    pipeline register enables (PC, IF/ID .. MEM/WB)
//   if_id_flush, id_ex_flush   load a bubble into IF/ID or ID/EX
//   fwd_a, fwd_b               ALU operand select: 00 RF, 01 MEM/WB, 10 EX/MEM
//   halted                     core stopped (registered)
//   stall_cycles               saturating count of cycles with the PC frozen
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_access,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             id_halt,
    input  logic             wb_halt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             halt_q, halt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [1:0] eff_state;
    logic [4:0] en;         // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic       load_use;
    logic       mem_stall;

    // Forwarding: the younger producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1)
            fwd_a = 2'b10;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1)
            fwd_a = 2'b01;
        fwd_b = 2'b00;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2)
            fwd_b = 2'b10;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2)
            fwd_b = 2'b01;
    end

    assign load_use  = ex_memread && ex_rd != 5'd0 &&
                       (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign mem_stall = mem_access && !mem_ready;

    // The cycle a memory wait completes behaves exactly like a cycle of the
    // state being resumed, so fold it into that state's rules.
    always_comb begin
        eff_state = state_q;
        if (state_q == S_MEM_WAIT && mem_ready)
            eff_state = halt_q ? S_DRAIN : S_RUN;
    end

    always_comb begin
        en          = 5'b11111;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = eff_state;
        halt_d      = halt_q;
        case (eff_state)
            S_RUN: begin
                if (mem_stall) begin
                    // Whole pipe freezes; redirect/load-use re-present later.
                    en      = 5'b00000;
                    state_d = S_MEM_WAIT;
                end else begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        en[4:3]     = 2'b00;
                        id_ex_flush = 1'b1;
                    end
                    // A halt in ID under a redirect is on the wrong path.
                    if (id_halt && !ex_redirect) begin
                        halt_d  = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
                if (wb_halt)
                    state_d = S_HALTED;
            end
            S_DRAIN: begin
                if (mem_stall) begin
                    en      = 5'b00000;
                    state_d = S_MEM_WAIT;
                end else begin
                    en[4]       = 1'b0;
                    if_id_flush = 1'b1;
                end
                if (wb_halt)
                    state_d = S_HALTED;
            end
            default: begin
                // MEM_WAIT still waiting, or HALTED: everything frozen.
                en = 5'b00000;
            end
        endcase
    end

    assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = en;

    always_comb begin
        halted_d       = (state_d == S_HALTED);
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && state_q != S_HALTED && stall_cycles_q != {CNT_W{1'b1}})
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RUN;
            halt_q         <= 1'b0;
            halted_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            halt_q         <= halt_d;
            halted_q       <= halted_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign halted       = halted_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_memread, ex_redirect, mem_regwrite, mem_access, mem_ready;
    logic wb_regwrite, id_halt, wb_halt;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
        .mem_ready(mem_ready), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .id_halt(id_halt), .wb_halt(wb_halt),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_state;
    bit m_halt;
    int m_cnt;
    bit m_halted;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs and successor from the rules, given current inputs.
    task automatic model(output logic [4:0] e, output logic fi, output logic fe,
                         output int nxt, output bit nh);
        int mode;
        bit lu, ms;
        lu = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        ms = mem_access && !mem_ready;
        mode = rst_n ? m_state : M_RUN;
        nh = rst_n ? m_halt : 1'b0;
        e = 5'h1f; fi = 0; fe = 0;
        if (mode == M_WAIT) begin
            if (!mem_ready) begin
                e = 0; nxt = M_WAIT; return;
            end
            mode = nh ? M_DRAIN : M_RUN;
        end
        nxt = mode;
        if (mode == M_HALT) begin
            e = 0; return;
        end
        if (ms) begin
            e = 0; nxt = M_WAIT;
        end else if (mode == M_DRAIN) begin
            e[4] = 0; fi = 1;
        end else begin
            if (ex_redirect) begin fi = 1; fe = 1; end
            else if (lu) begin e[4] = 0; e[3] = 0; fe = 1; end
            if (id_halt && !ex_redirect) begin nh = 1; nxt = M_DRAIN; end
        end
        if (wb_halt) nxt = M_HALT;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cyc();
        logic [4:0] e;
        logic fi, fe;
        int nxt;
        bit nh;
        #1;
        model(e, fi, fe, nxt, nh);
        chk("enables", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'(e));
        chk("flushes", 32'({if_id_flush, id_ex_flush}), 32'({fi, fe}));
        chk("fwd_a", 32'(fwd_a), 32'(pick(ex_rs1)));
        chk("fwd_b", 32'(fwd_b), 32'(pick(ex_rs2)));
        @(posedge clk);
        if (rst_n) begin
            if (!e[4] && m_state != M_HALT && m_cnt != MAXC) m_cnt++;
            m_state = nxt;
            m_halt = nh;
            m_halted = (nxt == M_HALT);
        end
        #1;
        chk("halted", 32'(halted), 32'(m_halted));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_memread = 0; ex_redirect = 0; mem_regwrite = 0; mem_access = 0;
        mem_ready = 0; wb_regwrite = 0; id_halt = 0; wb_halt = 0;
    endtask

    task automatic model_reset();
        m_state = M_RUN; m_halt = 0; m_cnt = 0; m_halted = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
        wb_rd = 5'($urandom_range(0, 3));
        ex_memread = 1'($urandom_range(0, 1)); ex_redirect = ($urandom_range(0, 5) == 0);
        mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
        mem_access = 1'($urandom_range(0, 1)); mem_ready = ($urandom_range(0, 3) != 0);
        id_halt = ($urandom_range(0, 29) == 0); wb_halt = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        // Reset-state outputs with all inputs 0
        chk("rst_enables", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'h1f);
        chk("rst_flushes", 32'({if_id_flush, id_ex_flush}), 32'h0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        do_reset();

        // Load-use: one stall cycle
        idle(); mem_ready = 1; cyc();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5;
        #1;
        chk("lu_pc_write", 32'(pc_write), 32'h0);
        chk("lu_if_id_write", 32'(if_id_write), 32'h0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 32'h1);
        cyc();
        idle(); mem_ready = 1; cyc();
        chk("lu_stall_count", 32'(stall_cycles), 32'd1);

        // Forwarding priority
        mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regwrite = 1; wb_regwrite = 1;
        #1; chk("fwd_exmem", 32'(fwd_a), 32'h2); cyc();
        mem_rd = 0;
        #1; chk("fwd_memwb", 32'(fwd_a), 32'h1); cyc();
        wb_rd = 0;
        #1; chk("fwd_none", 32'(fwd_a), 32'h0); cyc();

        // Memory wait with a pending redirect
        do_reset();
        idle(); mem_access = 1; mem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_enables", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'h0);
            chk("mw_noflush", 32'({if_id_flush, id_ex_flush}), 32'h0);
            cyc();
        end
        mem_ready = 1;
        #1; chk("mw_release", 32'({pc_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'hf);
        cyc();
        chk("mw_stall_count", 32'(stall_cycles), 32'd3);

        // Halt drain then stop
        do_reset();
        idle(); mem_ready = 1; id_halt = 1; cyc();
        id_halt = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_pc_write", 32'(pc_write), 32'h0);
            chk("drain_if_id_flush", 32'(if_id_flush), 32'h1);
            cyc();
        end
        wb_halt = 1; cyc();
        wb_halt = 0; cyc();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_enables", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}), 32'h0);

        // Halt under redirect is discarded
        do_reset();
        idle(); mem_ready = 1; id_halt = 1; ex_redirect = 1; cyc();
        idle(); mem_ready = 1;
        #1; chk("halt_discard", 32'(pc_write), 32'h1);
        cyc();

        // Asynchronous reset mid-drain
        id_halt = 1; cyc();
        id_halt = 0; cyc(); cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_halted", 32'(halted), 32'h0);
        chk("async_stall", 32'(stall_cycles), 32'h0);
        chk("async_pc_write", 32'(pc_write), 32'h1);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;

        // Saturation
        idle(); mem_ready = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5;
        for (int i = 0; i < MAXC + 3; i++) cyc();
        chk("sat_value", 32'(stall_cycles), 32'(MAXC));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (m_state == M_HALT && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 299) == 0) begin
                rand_inputs();
                rst_n = 1'b0;
                model_reset();
                cyc();
                rst_n = 1'b1;
            end else begin
                rand_inputs();
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the stall-cycle counter.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-003 SHALL have ports, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- ex_rs1, ex_rs2  in  5 each  RS_One/RS_Two from the ID/EX register
- ex_rd  in  5  rd from ID/EX
- ex_memread  in  1  MemRead from ID/EX
- ex_redirect  in  1  branch taken or jal/jalr resolved in EX
- mem_rd  in  5  rd from EX/MEM
- mem_regwrite  in  1  RegWrite from EX/MEM
- mem_access  in  1  MemRead or MemWrite from EX/MEM
- mem_ready  in  1  data memory completes the access this cycle
- wb_rd  in  5  rd from MEM/WB
- wb_regwrite  in  1  RegWrite from MEM/WB
- id_halt  in  1  halt decoded in ID
- wb_halt  in  1  halt from MEM/WB
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  register enables
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all control fields 0) into IF/ID or ID/EX
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 01 MEM/WB, 10 EX/MEM
- halted  out  1  core stopped
- stall_cycles  out  CNT_W  saturating count of non-RUN or stalled cycles

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED; all outputs are combinational from state and inputs except halted and stall_cycles, which are registered.
REQ-005 The fwd_a select SHALL be 10 if mem_regwrite, mem_rd != 0 and mem_rd == ex_rs1; else 01 if wb_regwrite, wb_rd != 0 and wb_rd == ex_rs1; else 00.
REQ-006 The fwd_b select SHALL follow the REQ-005 rule using ex_rs2; EX/MEM wins when both stages match.
REQ-007 Load-use SHALL be the condition ex_memread, ex_rd != 0 and (ex_rd == id_rs1 or ex_rd == id_rs2).
REQ-008 In RUN on load-use (without ex_redirect), the block SHALL drive pc_write=0, if_id_write=0 and id_ex_flush=1 for exactly that cycle; all other enables stay 1.
REQ-009 In RUN on ex_redirect, the block SHALL drive if_id_flush=1 and id_ex_flush=1 with pc_write=1; redirect overrides load-use.
REQ-010 In RUN, when mem_access=1 and mem_ready=0, the FSM SHALL go to MEM_WAIT.
REQ-011 In that same cycle, all five write enables SHALL be 0 and both flushes 0; redirect and load-use are ignored that cycle.
REQ-012 In MEM_WAIT, all write enables SHALL be 0 while mem_ready=0.
REQ-013 On mem_ready=1 in MEM_WAIT, the block SHALL drive all enables as in RUN and return to RUN, or to DRAIN if a halt was latched.
REQ-014 In RUN, id_halt=1 with ex_redirect=0 SHALL latch a halt and go to DRAIN; id_halt together with ex_redirect SHALL be discarded.
REQ-015 In DRAIN, the block SHALL hold pc_write=0 and if_id_flush=1; the ID/EX through MEM/WB enables stay 1 and MEM_WAIT rules still apply.
REQ-016 In DRAIN (or RUN), wb_halt=1 SHALL move the FSM to HALTED next cycle.
REQ-017 In HALTED, all enables SHALL be 0, halted=1, and the FSM stays there until reset.
REQ-018 stall_cycles SHALL increment each cycle in which pc_write=0 and the state is not HALTED, saturating at all-ones.

Reset
REQ-019 While rst_n=0, the block SHALL hold state=RUN, halt latch=0, halted=0 and stall_cycles=0, asynchronously, including mid-MEM_WAIT or mid-DRAIN.
REQ-020 With rst_n=0 and all inputs 0, outputs SHALL be: all enables 1, flushes 0, fwd 00.

Verification
REQ-021 Load-use: ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
REQ-022 Forward priority: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 -> fwd_a=10; with mem_rd=0 -> fwd_a=01; with rd=0 in both -> fwd_a=00.
REQ-023 Memory wait: mem_access=1 with mem_ready=0 for 3 cycles, plus ex_redirect=1 -> all enables 0 for 3 cycles, no flush; on the 4th cycle enables=1; stall_cycles=3.
REQ-024 Halt: id_halt pulse, wb_halt 3 cycles later -> pc_write=0 and if_id_flush=1 during drain, then halted=1 and all enables 0; id_halt with ex_redirect -> no effect.
REQ-025 Reset mid-DRAIN: assert rst_n=0 asynchronously -> state RUN, halted=0 and stall_cycles=0 immediately.
REQ-026 Saturation: force 2^CNT_W+2 stall cycles -> stall_cycles holds at all-ones.
